// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and the sequential fetch stride.
package cpu_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  localparam int unsigned FETCH_INC = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries; head is read combinationally.
module prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue with one-outstanding-request memory port and flush redirect.
// Optional macro PREFETCH_PERF_EN builds the consumer-starvation counter.
module prefetch_unit import cpu_pkg::*; #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       perf_starve_cnt
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;

  logic               ack_hit, push, pop, room;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occ_after;
  logic [ENTRY_W-1:0] fifo_head;

  prefetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mem_addr_q, mem_rdata}),
    .pop       (pop),
    .clear     (flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush && req_q && !mem_ack) state_d = DISCARD;
      DISCARD: if (mem_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign ack_hit   = req_q & mem_ack;
  assign pop       = instr_valid & instr_ready & ~flush;
  assign push      = (state_q == RUN) & ack_hit & ~flush;
  assign occ_after = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  // Outstanding request count after this edge is zero here, so occupancy alone bounds issue.
  assign room      = occ_after < (CNT_W+1)'(DEPTH);

  // fetch_addr_q is the address of the request in flight, or of the next one to issue.
  always_comb begin
    req_d        = req_q;
    mem_addr_d   = mem_addr_q;
    fetch_addr_d = fetch_addr_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          fetch_addr_d = flush_addr;
          if (!req_q || mem_ack) begin
            req_d      = 1'b1;
            mem_addr_d = flush_addr;
          end
        end else begin
          if (ack_hit) fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_INC);
          if (!req_q || mem_ack) begin
            req_d      = room;
            mem_addr_d = fetch_addr_d;
          end
        end
      end
      DISCARD: begin
        if (flush) fetch_addr_d = flush_addr;
        if (mem_ack) begin
          req_d      = 1'b1;
          mem_addr_d = fetch_addr_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= 1'b0;
      mem_addr_q   <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
    end else begin
      req_q        <= req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (fifo_count != '0);
  assign instr_data  = instr_valid ? fifo_head[DATA_W-1:0] : '0;
  assign instr_pc    = instr_valid ? fifo_head[ENTRY_W-1:DATA_W] : '0;

`ifdef PREFETCH_PERF_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (instr_ready && !instr_valid && !flush && (starve_q != '1)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign perf_starve_cnt = starve_q;
`else
  assign perf_starve_cnt = '0;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: streaming, back-pressure, flush/discard, wrap, perf counter.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset, flush, mem_req, mem_ack, instr_valid, instr_ready;
  logic [31:0] flush_addr, mem_addr, mem_rdata, instr_data, instr_pc, perf_starve_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int acks;

  always #5 clk = ~clk;

  // Memory returns a recognisable function of the address.
  assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

  prefetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .perf_starve_cnt (perf_starve_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; flush_addr = '0; mem_ack = 1'b0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",   64'(mem_req), 64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_data",  64'(instr_data), 64'(0));
    check("rst_pc",    64'(instr_pc), 64'(0));
    check("rst_perf",  64'(perf_starve_cnt), 64'(0));

    // Streaming with ack tied high and a ready consumer.
    mem_ack = 1'b1; instr_ready = 1'b1; reset = 1'b0;
    @(negedge clk);
    check("st_req0",   64'(mem_req), 64'(1));
    check("st_addr0",  64'(mem_addr), 64'(0));
    check("st_valid0", 64'(instr_valid), 64'(0));
    @(negedge clk);
    check("st_valid1", 64'(instr_valid), 64'(1));
    check("st_pc0",    64'(instr_pc), 64'(0));
    check("st_data0",  64'(instr_data), 64'(dat(32'h0)));
    check("st_addr1",  64'(mem_addr), 64'(4));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("st_pc",   64'(instr_pc), 64'(4 * i));
      check("st_data", 64'(instr_data), 64'(dat(32'(4 * i))));
    end

    // Back-pressure: queue fills to DEPTH, then requests stop.
    reset = 1'b1; instr_ready = 1'b0; mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    check("full_acks",  64'(acks), 64'(4));
    check("full_req",   64'(mem_req), 64'(0));
    check("full_valid", 64'(instr_valid), 64'(1));
    instr_ready = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc",   64'(instr_pc), 64'(4 * i));
      check("drain_data", 64'(instr_data), 64'(dat(32'(4 * i))));
      @(negedge clk);
    end
    check("drain_empty", 64'(instr_valid), 64'(0));
    check("hold_req",    64'(mem_req), 64'(1));
    check("hold_addr",   64'(mem_addr), 64'(32'h10));

    // Flush with the 0x10 request outstanding: its data must be dropped.
    flush = 1'b1; flush_addr = 32'h100;
    @(negedge clk);
    flush = 1'b0;
    check("disc_valid", 64'(instr_valid), 64'(0));
    check("disc_req",   64'(mem_req), 64'(1));
    check("disc_addr",  64'(mem_addr), 64'(32'h10));
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("disc_drop",  64'(instr_valid), 64'(0));
    check("redir_req",  64'(mem_req), 64'(1));
    check("redir_addr", 64'(mem_addr), 64'(32'h100));
    mem_ack = 1'b1;
    @(negedge clk);
    check("redir_valid", 64'(instr_valid), 64'(1));
    check("redir_pc",    64'(instr_pc), 64'(32'h100));
    check("redir_data",  64'(instr_data), 64'(dat(32'h100)));
    check("redir_next",  64'(mem_addr), 64'(32'h104));

    // Flush coinciding with ack (and with a pop): drop, no DISCARD.
    flush = 1'b1; flush_addr = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    check("coin_valid", 64'(instr_valid), 64'(0));
    check("coin_req",   64'(mem_req), 64'(1));
    check("coin_addr",  64'(mem_addr), 64'(32'h200));
    @(negedge clk);
    check("coin_pc",    64'(instr_pc), 64'(32'h200));
    check("coin_data",  64'(instr_data), 64'(dat(32'h200)));

    // Address wrap at the top of the space.
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    check("wrap_addr0", 64'(mem_addr), 64'(32'hFFFF_FFFC));
    @(negedge clk);
    check("wrap_addr1", 64'(mem_addr), 64'(0));
    check("wrap_pc0",   64'(instr_pc), 64'(32'hFFFF_FFFC));
    @(negedge clk);
    check("wrap_pc1",   64'(instr_pc), 64'(0));
    check("wrap_addr2", 64'(mem_addr), 64'(4));

    // Repeated flush while discarding: the latest flush_addr wins.
    mem_ack = 1'b0;
    @(negedge clk);
    check("dd_hold", 64'(mem_addr), 64'(4));
    flush = 1'b1; flush_addr = 32'h300;
    @(negedge clk);
    check("dd_empty", 64'(instr_valid), 64'(0));
    flush_addr = 32'h400;
    @(negedge clk);
    flush = 1'b0;
    check("dd_addr_old", 64'(mem_addr), 64'(4));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("dd_drop", 64'(instr_valid), 64'(0));
    check("dd_addr", 64'(mem_addr), 64'(32'h400));

    // Starvation counter: ready consumer, memory never answers.
    reset = 1'b1; mem_ack = 1'b0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("perf_rst", 64'(perf_starve_cnt), 64'(0));
    reset = 1'b0;
    repeat (11) @(negedge clk);
    check("perf_req",  64'(mem_req), 64'(1));
    check("perf_addr", 64'(mem_addr), 64'(0));
`ifdef PREFETCH_PERF_EN
    check("perf_cnt", 64'(perf_starve_cnt), 64'(11));
`else
    check("perf_cnt", 64'(perf_starve_cnt), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
